dmem_sram_responder: RTL and testbench

//  Data-memory responder: the slave end of the data SRAM port driven by the store/load path.

---
 rtl/dmem_sram_responder.sv | 117 +++++++++++
 tb/tb_dmem_sram_responder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_sram_responder.sv
// Data-memory responder: single-outstanding SRAM slave with fixed access latency.
// Accepts one word-aligned request at a time. Does a byte-masked write or a full-word read, then pulses data_ok.
module dmem_sram_responder #(
  parameter int AW      = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0] BUSY_CNT = 4'(LATENCY - 2);

  state_t         state_q;
  logic [3:0]     cnt_q;
  logic           wr_q;
  logic [3:0]     wstrb_q;
  logic [AW-1:0]  idx_q;
  logic [31:0]    wdata_q;
  logic           data_ok_q;
  logic [31:0]    rdata_q;
  logic [31:0]    mem_q [2**AW];

  logic           acc_en;
  logic           acc_wr;
  logic [3:0]     acc_strb;
  logic [AW-1:0]  acc_idx;
  logic [31:0]    acc_wdata;
  logic           unused_addr;

  assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
  assign addr_ok     = (state_q == IDLE) && !reset;
  assign data_ok     = data_ok_q;
  assign rdata       = rdata_q;

  // With LATENCY==1 the access happens on the accepting edge, so it must use the live request inputs.
  always_comb begin
    acc_en    = 1'b0;
    acc_wr    = wr_q;
    acc_strb  = wstrb_q;
    acc_idx   = idx_q;
    acc_wdata = wdata_q;
    if (!reset) begin
      if (state_q == IDLE && req && LATENCY == 1) begin
        acc_en    = 1'b1;
        acc_wr    = wr;
        acc_strb  = wstrb;
        acc_idx   = addr[AW+1:2];
        acc_wdata = wdata;
      end else if (state_q == BUSY && cnt_q == 4'd0) begin
        acc_en = 1'b1;
      end
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (acc_en && acc_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_strb[i]) mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      wr_q      <= 1'b0;
      wstrb_q   <= 4'd0;
      idx_q     <= '0;
      wdata_q   <= 32'd0;
      data_ok_q <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      data_ok_q <= 1'b0;
      if (acc_en && !acc_wr) rdata_q <= mem_q[acc_idx];
      case (state_q)
        IDLE: begin
          if (req) begin
            wr_q    <= wr;
            wstrb_q <= wstrb;
            idx_q   <= addr[AW+1:2];
            wdata_q <= wdata;
            if (LATENCY == 1) begin
              state_q   <= RESP;
              data_ok_q <= 1'b1;
            end else begin
              state_q <= BUSY;
              cnt_q   <= BUSY_CNT;
            end
          end
        end
        BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q   <= RESP;
            data_ok_q <= 1'b1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_sram_responder.sv
// Bench for dmem_sram_responder: three instances (LATENCY 1, 2, 3) checked every cycle
// against a transaction-level model, plus directed literal expectations.
module tb_dmem_sram_responder;

  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_v;
  logic        wr;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  aok;
  logic [2:0]  dok;
  logic [31:0] rdat [3];

  always #5 clk = ~clk;

  dmem_sram_responder #(.AW(AW), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .req(req_v[0]), .wr(wr), .wstrb(wstrb), .addr(addr),
    .wdata(wdata), .addr_ok(aok[0]), .data_ok(dok[0]), .rdata(rdat[0]));
  dmem_sram_responder #(.AW(AW), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .req(req_v[1]), .wr(wr), .wstrb(wstrb), .addr(addr),
    .wdata(wdata), .addr_ok(aok[1]), .data_ok(dok[1]), .rdata(rdat[1]));
  dmem_sram_responder #(.AW(AW), .LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .req(req_v[2]), .wr(wr), .wstrb(wstrb), .addr(addr),
    .wdata(wdata), .addr_ok(aok[2]), .data_ok(dok[2]), .rdata(rdat[2]));

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic int lat_of(int k);
    return k + 1;
  endfunction

  // Transaction model: one pending request per instance, response due LATENCY cycles after acceptance.
  int          cyc = 0;
  bit          armed = 1'b0;
  bit          pend [3];
  int          resp [3];
  bit          p_wr [3];
  logic [3:0]  p_strb [3];
  int          p_idx [3];
  logic [31:0] p_wd [3];
  logic [31:0] rexp [3];
  logic [31:0] mem_m [int];

  task automatic apply(int k);
    int key;
    logic [31:0] w;
    key = k * 1024 + p_idx[k];
    w = mem_m.exists(key) ? mem_m[key] : 32'hxxxx_xxxx;
    if (p_wr[k]) begin
      for (int b = 0; b < 4; b++) if (p_strb[k][b]) w[8*b +: 8] = p_wd[k][8*b +: 8];
      if (p_strb[k] != 4'd0) mem_m[key] = w;
    end else begin
      rexp[k] = w;
    end
  endtask

  always @(posedge clk) begin
    int c;
    c = cyc;
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        pend[k] = 1'b0;
        rexp[k] = 32'd0;
      end else begin
        if (req_v[k] && !(pend[k] && c <= resp[k])) begin
          pend[k]   = 1'b1;
          resp[k]   = c + lat_of(k);
          p_wr[k]   = wr;
          p_strb[k] = wstrb;
          p_idx[k]  = int'((addr >> 2) & 32'h3FF);
          p_wd[k]   = wdata;
        end
        if (pend[k] && resp[k] == c + 1) apply(k);
      end
    end
    if (reset) armed = 1'b1;
    cyc = c + 1;
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("addr_ok[L%0d]", lat_of(k)), 32'(aok[k]),
            32'(!reset && !(pend[k] && cyc <= resp[k])));
        chk($sformatf("data_ok[L%0d]", lat_of(k)), 32'(dok[k]), 32'(pend[k] && cyc == resp[k]));
        if (!$isunknown(rexp[k])) chk($sformatf("rdata[L%0d]", lat_of(k)), rdat[k], rexp[k]);
      end
    end
  end

  // Issue one request to an idle instance; returns the read data and cycles from acceptance to data_ok.
  task automatic xact(int k, bit w, logic [3:0] s, logic [31:0] a, logic [31:0] d,
                      output logic [31:0] rd, output int lat);
    req_v[k] = 1'b1; wr = w; wstrb = s; addr = a; wdata = d;
    @(posedge clk);
    #1;
    req_v[k] = 1'b0; wr = ~w; addr = 32'hDEAD_BEEF; wdata = 32'h5555_AAAA;
    lat = 0;
    rd  = 32'hxxxx_xxxx;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      if (dok[k]) begin
        lat = i;
        rd  = rdat[k];
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int lat, acc_n, dok_n;
    reset = 1'b1; req_v = 3'b000; wr = 1'b0; wstrb = 4'd0; addr = 32'd0; wdata = 32'd0;

    // reset behaviour
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst addr_ok", 32'(aok), 32'd0);
      chk("rst data_ok", 32'(dok), 32'd0);
      chk("rst rdata", rdat[1], 32'd0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post-reset addr_ok", 32'(aok), 32'h7);
    @(posedge clk);
    #1;

    // full-word write and read, LATENCY 2
    xact(1, 1'b1, 4'hF, 32'h10, 32'h1234_5678, rd, lat);
    chk("t2 write latency", 32'(lat), 32'd2);
    chk("t2 addr_ok at T+3", 32'(aok[1]), 32'd1);
    xact(1, 1'b0, 4'hF, 32'h10, 32'd0, rd, lat);
    chk("t2 read latency", 32'(lat), 32'd2);
    chk("t2 read data", rd, 32'h1234_5678);

    // byte lanes
    xact(1, 1'b1, 4'b0100, 32'h10, 32'h00AB_0000, rd, lat);
    xact(1, 1'b0, 4'b0000, 32'h10, 32'd0, rd, lat);
    chk("t3 lane2 write", rd, 32'h12AB_5678);
    xact(1, 1'b1, 4'b0000, 32'h10, 32'hFFFF_FFFF, rd, lat);
    chk("t3 null write latency", 32'(lat), 32'd2);
    xact(1, 1'b0, 4'hF, 32'h10, 32'd0, rd, lat);
    chk("t3 null write no-op", rd, 32'h12AB_5678);

    // aliasing
    xact(1, 1'b0, 4'hF, 32'h13, 32'd0, rd, lat);
    chk("t4 alias 0x13", rd, 32'h12AB_5678);
    xact(1, 1'b0, 4'hF, 32'h1010, 32'd0, rd, lat);
    chk("t4 alias 0x1010", rd, 32'h12AB_5678);

    // req held, address changing every cycle: accepts at j=0,3,6
    acc_n = 0; dok_n = 0;
    for (int j = 0; j < 9; j++) begin
      req_v[1] = 1'b1; wr = 1'b1; wstrb = 4'hF;
      addr = 32'h100 + 32'(4 * j); wdata = 32'hA000_0000 + 32'(j);
      @(negedge clk);
      acc_n += int'(aok[1] && req_v[1]);
      dok_n += int'(dok[1]);
      @(posedge clk);
      #1;
    end
    req_v[1] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      dok_n += int'(dok[1]);
      @(posedge clk);
      #1;
    end
    chk("t5 accepts", 32'(acc_n), 32'd3);
    chk("t5 responses", 32'(dok_n), 32'd3);
    xact(1, 1'b0, 4'hF, 32'h10C, 32'd0, rd, lat);
    chk("t5 word 0x10C", rd, 32'hA000_0003);
    xact(1, 1'b0, 4'hF, 32'h118, 32'd0, rd, lat);
    chk("t5 word 0x118", rd, 32'hA000_0006);
    xact(1, 1'b0, 4'hF, 32'h100, 32'd0, rd, lat);
    chk("t5 word 0x100", rd, 32'hA000_0000);

    // reset and req together: request dropped
    req_v[1] = 1'b1; reset = 1'b1; wr = 1'b1; wstrb = 4'hF; addr = 32'h10; wdata = 32'd0;
    @(negedge clk);
    chk("rst+req addr_ok", 32'(aok[1]), 32'd0);
    @(posedge clk);
    #1 req_v[1] = 1'b0; reset = 1'b0;
    dok_n = 0;
    repeat (4) begin
      @(negedge clk);
      dok_n += int'(dok[1]);
    end
    chk("rst+req no response", 32'(dok_n), 32'd0);
    @(posedge clk);
    #1;
    xact(1, 1'b0, 4'hF, 32'h10, 32'd0, rd, lat);
    chk("rst+req word kept", rd, 32'h12AB_5678);

    // LATENCY 3: reset during BUSY discards the write
    xact(2, 1'b1, 4'hF, 32'h20, 32'd0, rd, lat);
    chk("t6 L3 latency", 32'(lat), 32'd3);
    req_v[2] = 1'b1; wr = 1'b1; wstrb = 4'hF; addr = 32'h20; wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1 req_v[2] = 1'b0; reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    dok_n = 0;
    repeat (5) begin
      @(negedge clk);
      dok_n += int'(dok[2]);
    end
    chk("t6 L3 no response", 32'(dok_n), 32'd0);
    @(posedge clk);
    #1;
    xact(2, 1'b0, 4'hF, 32'h20, 32'd0, rd, lat);
    chk("t6 L3 write discarded", rd, 32'd0);

    // LATENCY 1: write commits on the accepting edge, so it survives a following reset
    xact(0, 1'b1, 4'hF, 32'h20, 32'd0, rd, lat);
    chk("t6 L1 latency", 32'(lat), 32'd1);
    req_v[0] = 1'b1; wr = 1'b1; wstrb = 4'hF; addr = 32'h20; wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1 req_v[0] = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("t6 L1 data_ok at T+1", 32'(dok[0]), 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    xact(0, 1'b0, 4'hF, 32'h20, 32'd0, rd, lat);
    chk("t6 L1 write committed", rd, 32'hCAFE_F00D);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
